vault_key_entry: RTL and testbench

- Credential front-end for the bank vault lock controller; it drives that controller's P, VP[1:0] and Open inputs.
- Debounces the raw key switches for the President, the two Vice-Presidents and the bank-open switch.
- Collects key presentations within a timed window, so officers need not turn keys simultaneously.
- Asserts the authorization outputs only for a bounded grant period, and enforces a lockout after repeated failed windows.

---
 rtl/vault_key_entry.sv | 186 ++++++++++++++++++
 tb/tb_vault_key_entry.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vault_key_entry.sv
// Vault credential front-end: debounces key switches, collects keys within a timed window,
// grants P/VP for a bounded period and locks out after repeated failures. VAULT_ALARM_EN adds 'alarm'.
module vault_key_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned WINDOW_CYCLES   = 1000000000,
    parameter int unsigned GRANT_CYCLES    = 500000000,
    parameter int unsigned MAX_FAILS       = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 32'd3000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_p,
    input  logic [1:0] sw_vp,
    input  logic       sw_open,
    output logic       P,
    output logic [1:0] VP,
    output logic       Open,
    output logic [1:0] state,
    output logic [3:0] fail_cnt
`ifdef VAULT_ALARM_EN
    ,
    output logic       alarm
`endif
);

    localparam int unsigned NIN   = 4;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned GNT_W = $clog2(GRANT_CYCLES);
    localparam int unsigned LCK_W = $clog2(LOCKOUT_CYCLES);
    localparam int unsigned WG_W  = (WIN_W > GNT_W) ? WIN_W : GNT_W;
    localparam int unsigned MX_W  = (WG_W > LCK_W) ? WG_W : LCK_W;
    localparam int unsigned CNT_W = (MX_W > 0) ? MX_W : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        GRANT   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Bit order: [0]=President, [2:1]=Vice-Presidents, [3]=bank-open
    logic [NIN-1:0]  sync1, sync2, db;
    logic [DB_W-1:0] db_cnt [NIN];
    logic [2:0]      db_d, key_rise;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       keys_q, keys_nxt, keys_cand;
    logic [3:0]       fail_q, fail_nxt, fail_inc;
    logic [2:0]       auth_nxt;
    logic             open_nxt;
    logic             quorum;

    // Synchronize, debounce and detect debounced key rises
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db       <= '0;
            db_d     <= '0;
            key_rise <= '0;
            for (int i = 0; i < NIN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= {sw_open, sw_vp, sw_p};
            sync2    <= sync1;
            db_d     <= db[2:0];
            key_rise <= db[2:0] & ~db_d;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            keys_q  <= '0;
            fail_q  <= '0;
            P       <= 1'b0;
            VP      <= '0;
            Open    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            keys_q  <= keys_nxt;
            fail_q  <= fail_nxt;
            P       <= auth_nxt[0];
            VP      <= auth_nxt[2:1];
            Open    <= open_nxt;
        end
    end

    // Quorum includes a key rising in the current cycle so a last-cycle key still wins
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + CNT_W'(1);
        keys_nxt  = keys_q;
        fail_nxt  = fail_q;
        auth_nxt  = {VP, P};
        keys_cand = keys_q | key_rise;
        fail_inc  = fail_q + 4'd1;
        quorum    = (keys_cand[0] & keys_cand[2]) | (keys_cand[0] & keys_cand[1]) |
                    (db[3] & keys_cand[0]) | (db[3] & keys_cand[2] & keys_cand[1]);

        case (state_q)
            IDLE: begin
                cnt_nxt  = '0;
                auth_nxt = '0;
                if (|key_rise) begin
                    keys_nxt = keys_cand;
                    if (quorum) begin
                        state_nxt = GRANT;
                        auth_nxt  = keys_cand;
                        fail_nxt  = '0;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                keys_nxt = keys_cand;
                if (quorum) begin
                    state_nxt = GRANT;
                    cnt_nxt   = '0;
                    auth_nxt  = keys_cand;
                    fail_nxt  = '0;
                end else if (cnt_q == CNT_W'(WINDOW_CYCLES - 1)) begin
                    keys_nxt  = '0;
                    cnt_nxt   = '0;
                    fail_nxt  = fail_inc;
                    state_nxt = (fail_inc == 4'(MAX_FAILS)) ? LOCKOUT : IDLE;
                end
            end
            GRANT: begin
                if (cnt_q == CNT_W'(GRANT_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    keys_nxt  = '0;
                    auth_nxt  = '0;
                end
            end
            LOCKOUT: begin
                auth_nxt = '0;
                if (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    fail_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                keys_nxt  = '0;
                auth_nxt  = '0;
            end
        endcase

        open_nxt = (state_nxt == LOCKOUT) ? 1'b0 : db[3];
    end

    assign state    = state_q;
    assign fail_cnt = fail_q;

`ifdef VAULT_ALARM_EN
    // High through lockout, plus a one-cycle pulse for any key turned while locked out
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (state_nxt == LOCKOUT) | ((state_q == LOCKOUT) & (|key_rise));
        end
    end
`endif

endmodule

// File: tb/tb_vault_key_entry.sv
// Directed self-checking bench for vault_key_entry with short debounce/window/grant/lockout timings.
module tb_vault_key_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_p;
    logic [1:0] sw_vp;
    logic       sw_open;
    logic       P;
    logic [1:0] VP;
    logic       Open;
    logic [1:0] state;
    logic [3:0] fail_cnt;
`ifdef VAULT_ALARM_EN
    logic       alarm;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vault_key_entry #(
        .DEBOUNCE_CYCLES(4),
        .WINDOW_CYCLES  (50),
        .GRANT_CYCLES   (20),
        .MAX_FAILS      (2),
        .LOCKOUT_CYCLES (30)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_p    (sw_p),
        .sw_vp   (sw_vp),
        .sw_open (sw_open),
        .P       (P),
        .VP      (VP),
        .Open    (Open),
        .state   (state),
        .fail_cnt(fail_cnt)
`ifdef VAULT_ALARM_EN
        ,
        .alarm   (alarm)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // A switch driven just after an edge reaches the FSM transition 8 edges later
    // (2 sync + 4 debounce + 1 rise register + 1 state register).
    initial begin
        rst = 1'b1; sw_p = 1'b0; sw_vp = 2'b00; sw_open = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_state", 4'(state), 4'd0);
        chk("rst_p", 4'(P), 4'd0);
        chk("rst_vp", 4'(VP), 4'd0);
        chk("rst_open", 4'(Open), 4'd0);
        chk("rst_fail", fail_cnt, 4'd0);

        // 1: bounce rejection
        for (int i = 0; i < 10; i++) begin
            sw_p = ~sw_p;
            step(2);
            chk("bounce_state", 4'(state), 4'd0);
            chk("bounce_p", 4'(P), 4'd0);
        end
        sw_p = 1'b0;
        step(10);
        chk("bounce_settle", 4'(state), 4'd0);

        // 2: two-officer grant
        sw_p = 1'b1;
        step(7);  chk("s2_pre_collect", 4'(state), 4'd0);
        step(1);  chk("s2_collect", 4'(state), 4'd1);
        step(22);
        sw_vp = 2'b10;
        step(7);  chk("s2_pre_grant", 4'(state), 4'd1);
                  chk("s2_pre_grant_p", 4'(P), 4'd0);
        step(1);  chk("s2_grant", 4'(state), 4'd2);
                  chk("s2_p", 4'(P), 4'd1);
                  chk("s2_vp", 4'(VP), 4'd2);
        step(19); chk("s2_last_p", 4'(P), 4'd1);
                  chk("s2_last_vp", 4'(VP), 4'd2);
        step(1);  chk("s2_exit_state", 4'(state), 4'd0);
                  chk("s2_exit_p", 4'(P), 4'd0);
                  chk("s2_exit_vp", 4'(VP), 4'd0);
        sw_p = 1'b0; sw_vp = 2'b00;
        step(12); chk("s2_idle", 4'(state), 4'd0);

        // 3: open + President goes straight to grant
        sw_open = 1'b1;
        step(10); chk("s3_open", 4'(Open), 4'd1);
        sw_p = 1'b1;
        step(7);  chk("s3_pre", 4'(state), 4'd0);
        step(1);  chk("s3_grant", 4'(state), 4'd2);
                  chk("s3_p", 4'(P), 4'd1);
                  chk("s3_vp", 4'(VP), 4'd0);
                  chk("s3_open_g", 4'(Open), 4'd1);
        step(19); chk("s3_last_p", 4'(P), 4'd1);
        step(1);  chk("s3_exit_state", 4'(state), 4'd0);
                  chk("s3_exit_p", 4'(P), 4'd0);
        sw_p = 1'b0;
        step(12);

        // 4: expiry, expiry, lockout
        sw_vp = 2'b01;
        step(8);  chk("s4_collect1", 4'(state), 4'd1);
        step(49); chk("s4_w1_last", 4'(state), 4'd1);
                  chk("s4_w1_fail0", fail_cnt, 4'd0);
        step(1);  chk("s4_exp1_state", 4'(state), 4'd0);
                  chk("s4_exp1_fail", fail_cnt, 4'd1);
        sw_vp = 2'b00;
        step(10);
        sw_vp = 2'b01;
        step(8);  chk("s4_collect2", 4'(state), 4'd1);
        step(49); chk("s4_w2_last", 4'(state), 4'd1);
        step(1);  chk("s4_lock_state", 4'(state), 4'd3);
                  chk("s4_lock_fail", fail_cnt, 4'd2);
                  chk("s4_lock_open", 4'(Open), 4'd0);
`ifdef VAULT_ALARM_EN
                  chk("s4_alarm_on", 4'(alarm), 4'd1);
`endif
        step(29); chk("s4_lock_end", 4'(state), 4'd3);
                  chk("s4_lock_open_end", 4'(Open), 4'd0);
`ifdef VAULT_ALARM_EN
                  chk("s4_alarm_end", 4'(alarm), 4'd1);
`endif
        step(1);  chk("s4_exit_state", 4'(state), 4'd0);
                  chk("s4_exit_fail", fail_cnt, 4'd0);
                  chk("s4_exit_open", 4'(Open), 4'd1);
`ifdef VAULT_ALARM_EN
                  chk("s4_alarm_off", 4'(alarm), 4'd0);
`endif
        step(5);  chk("s4_held_no_edge", 4'(state), 4'd0);
        sw_vp = 2'b00; sw_open = 1'b0;
        step(12); chk("s4_open_off", 4'(Open), 4'd0);

        // 5: second key rise lands on the last window cycle
        sw_p = 1'b1;
        step(8);  chk("s5_collect", 4'(state), 4'd1);
        step(42);
        sw_vp = 2'b10;
        step(7);  chk("s5_pre", 4'(state), 4'd1);
        step(1);  chk("s5_grant", 4'(state), 4'd2);
                  chk("s5_fail", fail_cnt, 4'd0);
                  chk("s5_p", 4'(P), 4'd1);
                  chk("s5_vp", 4'(VP), 4'd2);

        // 6: reset in the middle of grant
        step(10); chk("s6_mid_p", 4'(P), 4'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("s6_state", 4'(state), 4'd0);
        chk("s6_p", 4'(P), 4'd0);
        chk("s6_vp", 4'(VP), 4'd0);
        chk("s6_fail", fail_cnt, 4'd0);
        sw_p = 1'b0; sw_vp = 2'b00;
        step(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
